// File: rtl/program_counter_pkg.sv
// Shared PC constants for the fetch unit, the branch unit and the top level.
package program_counter_pkg;

    localparam int                   PC_WIDTH     = 32;
    localparam logic [PC_WIDTH-1:0]  RESET_VECTOR = 32'h0000_0000;

    typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/program_counter_if.sv
// Next-PC / current-PC pair as seen by the PC register and whatever sits around it.
interface program_counter_if
    import program_counter_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH
);

    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;

    // The next-PC mux drives in and watches out.
    modport master  (output in, input  out);
    modport slave   (input  in, output out);
    modport monitor (input  in, input  out);

endinterface

// File: rtl/program_counter_sva.sv
// Property checker for the PC register: reset value, one-cycle latency and alignment.
module program_counter_sva
    import program_counter_pkg::*;
#(
    parameter int               WIDTH      = PC_WIDTH,
    parameter logic [WIDTH-1:0] RST_VALUE  = RESET_VECTOR,
    parameter int               ALIGN_LSBS = 0
) (
    input logic                  clk,
    input logic                  resetb,
    program_counter_if.monitor   bus
);

    localparam logic [WIDTH-1:0] MASK = {WIDTH{1'b1}} << ALIGN_LSBS;

    a_reset_value : assert property (
        @(posedge clk) !resetb |-> bus.out == RST_VALUE
    ) else $error("reset value not held");

    // Only meaningful when the previous edge was a real capture, not a reset.
    a_latency : assert property (
        @(posedge clk) (resetb && $past(resetb)) |-> bus.out == ($past(bus.in) & MASK)
    ) else $error("one-cycle capture violated");

    generate
        if (ALIGN_LSBS > 0) begin : g_align
            a_aligned : assert property (
                @(posedge clk) (resetb && $past(resetb)) |-> bus.out[ALIGN_LSBS-1:0] == '0
            ) else $error("captured PC not aligned");
        end
    endgenerate

endmodule

// File: rtl/program_counter.sv
// Architectural PC register: captures the upstream next-PC every rising edge and
// drops to the reset vector asynchronously while resetb is low.
module program_counter #(
    parameter int               WIDTH        = program_counter_pkg::PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = program_counter_pkg::RESET_VECTOR,
    parameter int               ALIGN_LSBS   = 0
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] in,
    input  logic             clk,
    input  logic             resetb
);

    // Clears the low ALIGN_LSBS bits; a shift by zero leaves the mask all ones.
    function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] value);
        return value & ({WIDTH{1'b1}} << ALIGN_LSBS);
    endfunction

    // NOTE: state is updated with <= so every reader sees the pre-edge value.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            out <= RESET_VECTOR;
        end else begin
            out <= align(in);
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// Randomised bench for program_counter: an unaligned and a word-aligned instance
// share one stimulus stream and are compared against a truncating-divide reference.
`timescale 1ns/1ps
module tb_program_counter;
    import program_counter_pkg::*;

    localparam int           W  = PC_WIDTH;
    localparam logic [W-1:0] RV = RESET_VECTOR;

    logic clk = 1'b0;
    logic resetb;

    program_counter_if #(.WIDTH(W)) pc_bus ();
    program_counter_if #(.WIDTH(W)) pc_bus_al ();

    assign pc_bus_al.in = pc_bus.in;

    program_counter #(.WIDTH(W), .RESET_VECTOR(RV), .ALIGN_LSBS(0)) dut (
        .out    (pc_bus.out),
        .in     (pc_bus.in),
        .clk    (clk),
        .resetb (resetb)
    );

    program_counter #(.WIDTH(W), .RESET_VECTOR(RV), .ALIGN_LSBS(2)) dut_al (
        .out    (pc_bus_al.out),
        .in     (pc_bus_al.in),
        .clk    (clk),
        .resetb (resetb)
    );

    program_counter_sva #(.WIDTH(W), .RST_VALUE(RV), .ALIGN_LSBS(0)) sva (
        .clk (clk), .resetb (resetb), .bus (pc_bus)
    );

    program_counter_sva #(.WIDTH(W), .RST_VALUE(RV), .ALIGN_LSBS(2)) sva_al (
        .clk (clk), .resetb (resetb), .bus (pc_bus_al)
    );

    // 2 us period
    always #1000 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] model_pc;
    logic [W-1:0] model_pc_al;

    // Alignment as integer truncation: drop the low bits, then scale back up.
    function automatic logic [W-1:0] ref_capture(input logic [W-1:0] value, input int lsbs);
        logic [W-1:0] q;
        q = value / (W'(1) << lsbs);
        return q * (W'(1) << lsbs);
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_both(input string tag);
        check(tag, pc_bus.out, model_pc);
        check({tag, "_al"}, pc_bus_al.out, model_pc_al);
    endtask

    // Called between edges; lets one rising edge pass and checks on the falling edge.
    task automatic edge_and_check(input string tag);
        @(posedge clk);
        if (resetb) begin
            model_pc    = ref_capture(pc_bus.in, 0);
            model_pc_al = ref_capture(pc_bus.in, 2);
        end
        @(negedge clk);
        check_both(tag);
    endtask

    task automatic apply(input logic [W-1:0] value, input string tag);
        pc_bus.in = value;
        #1;
        check_both({tag, "_hold"});
        edge_and_check(tag);
    endtask

    // Asserts reset mid-cycle, keeps it across some edges, releases on a falling edge.
    task automatic reset_pulse(input int edges, input logic [W-1:0] held_in);
        #500;
        resetb = 1'b0;
        #1;
        model_pc    = RV;
        model_pc_al = RV;
        check_both("async_reset");
        pc_bus.in = held_in;
        repeat (edges) edge_and_check("rst_dominance");
        resetb = 1'b1;
    endtask

    initial begin
        resetb    = 1'b1;
        pc_bus.in = '0;
        #10;
        resetb = 1'b0;
        #1;
        model_pc    = RV;
        model_pc_al = RV;
        check_both("por_reset");

        @(negedge clk);
        resetb = 1'b1;
        apply(32'h0000_0000, "first_edge");
        apply(32'hAAAA_AAAA, "pattern_a");
        apply(32'hAAAA_AAAA, "pattern_a_stable");
        apply(32'hFFFF_FFFF, "all_ones");

        reset_pulse(3, 32'h5555_5555);
        edge_and_check("rst_release");

        // Only the value present at the edge may be captured.
        pc_bus.in = 32'h0000_1000;
        #300;
        check_both("mid_cycle_a");
        pc_bus.in = 32'h0000_2000;
        #300;
        check_both("mid_cycle_b");
        edge_and_check("mid_cycle");

        apply(32'h0000_0007, "align_7");
        apply(32'h0000_0003, "align_3");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset_pulse(int'($urandom_range(1, 2)), W'($urandom));
                edge_and_check("rand_release");
            end else begin
                apply(W'($urandom), "random");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
